// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory slave: FSM state encoding,
// wait-counter width and the memory index-width helper.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int CNT_W = 4;

   // DEPTH is a power of two >= 2, so the index is exactly log2(DEPTH) bits.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// DEPTH x DATA_W single-port memory: synchronous write, registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module apb_slv_mem
   import apb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [idx_w(DEPTH)-1:0]  idx,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DATA_W-1:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[idx] <= wr_data;
      end
      if (rd_en) begin
         rd_data_reg <= mem_reg[idx];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/apb_mem_slave.sv
// APB3 memory slave with configurable wait states.
// Define APB_SLV_ERR_EN to answer out-of-range addresses with PSLVERR.
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              PCLK,
   input  logic              PRST,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam int IDX_W = idx_w(DEPTH);
   localparam logic [CNT_W-1:0]  WAIT_LD   = CNT_W'(WAIT_CYCLES);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
`ifdef APB_SLV_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   apb_state_e        state_reg;
   apb_state_e        phase;
   logic [CNT_W-1:0]  cnt_reg;
   logic              rd_zero_reg;
   logic              xfer_ok;
   logic              err_addr;
   logic              wr_en;
   logic              rd_en;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] mem_rd_data;

   assign idx      = PADDR[IDX_W-1:0];
   assign err_addr = ERR_EN && ({1'b0, PADDR} >= DEPTH_EXT);

   // The setup cycle is recognised combinationally from the bus, so the
   // registered state only ever holds IDLE or ACCESS; this keeps the total
   // latency at WAIT_CYCLES + 2 cycles counted from PSEL rising.
   always_comb begin
      phase = state_reg;
      if (state_reg != ACCESS) begin
         phase = (PSEL && !PENABLE) ? SETUP : IDLE;
      end
   end

   assign xfer_ok = (state_reg == ACCESS) && PSEL && PENABLE;
   assign PREADY  = xfer_ok && (cnt_reg == '0);
   assign PSLVERR = PREADY && err_addr;
   assign wr_en   = PREADY && PWRITE && !err_addr;

   // Read is launched on the edge that enters the final access cycle.
   assign rd_en = !PWRITE &&
                  (((phase == SETUP) && (WAIT_LD == '0)) ||
                   (xfer_ok && (cnt_reg == CNT_W'(1))));

   always_ff @(posedge PCLK or negedge PRST) begin
      if (!PRST) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         rd_zero_reg <= 1'b1;
      end else begin
         case (phase)
            SETUP: begin
               state_reg <= ACCESS;
               cnt_reg   <= WAIT_LD;
            end
            ACCESS: begin
               if (!xfer_ok || (cnt_reg == '0)) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
            end
         endcase
         if (rd_en) begin
            rd_zero_reg <= err_addr;
         end
      end
   end

   // rd_zero_reg masks the un-reset RAM output after reset and on error reads.
   assign PRDATA = rd_zero_reg ? '0 : mem_rd_data;

   apb_slv_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (PCLK),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .idx     (idx),
      .wr_data (PWDATA),
      .rd_data (mem_rd_data)
   );

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB3 memory slave: the next-generation peripheral endpoint behind the APB master/decoder. It adds configurable data/address width, memory depth and wait-state insertion to the earlier fixed 8-bit, 64-entry slaves. It also adds real read-data return, write commit and an optional out-of-range error response. One instance sits on each PSEL line of the APB interconnect.

## Interface
- DATA_W, 8, width of PWDATA/PRDATA and of each memory word
- ADDR_W, 8, width of PADDR
- DEPTH, 64, number of memory words; power of two, 2..2**ADDR_W
- WAIT_CYCLES, 0, wait states inserted per transfer (0..15)
- PCLK  in  1  APB clock; all state updates on rising edge
- PRST  in  1  reset; asynchronous, active-low
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  word address
- PWDATA  in  DATA_W  write data
- PRDATA  out  DATA_W  read data, registered
- PREADY  out  1  transfer-complete
- PSLVERR  out  1  error response, valid only with PREADY

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS next cycle; wait counter loads WAIT_CYCLES.
  - ACCESS: counter decrements each cycle while nonzero.
  - In ACCESS with counter == 0 and PSEL & PENABLE: PREADY = 1 combinationally; next state is SETUP if a back-to-back setup is presented, else IDLE.
- Index = PADDR[log2(DEPTH)-1:0]. Out-of-range = PADDR >= DEPTH (see Configuration).
- Write commits to mem[index] at the rising edge ending the PREADY cycle, never earlier.
- Read: PRDATA loads mem[index] at the edge entering the final ACCESS cycle, so it is valid while PREADY = 1. PRDATA holds until the next completed read.
- PSEL or PENABLE dropping in SETUP/ACCESS before completion (protocol violation): go to IDLE, no commit, PREADY stays 0.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: PREADY 0, PSLVERR 0, PRDATA 0, FSM IDLE, counter 0.
- Transfer latency: setup cycle + WAIT_CYCLES + 1 access cycle = WAIT_CYCLES + 2 cycles from PSEL rise to completion.
- WAIT_CYCLES = 0 gives zero-wait APB (PREADY in the first PENABLE cycle).
- Back-to-back transfers: a new setup may follow the completion cycle directly; no idle cycle is required.
- Reset asserted mid-transfer: immediate return to reset values; a pending write is dropped.
- Write then read to the same address in consecutive transfers returns the newly written value.

## Configuration
- APB_SLV_ERR_EN defined:
  - Out-of-range access completes normally (same latency) with PSLVERR = 1 during the PREADY cycle.
  - Writes are not committed; reads return PRDATA = 0.
- APB_SLV_ERR_EN undefined:
  - PSLVERR is tied 0.
  - Out-of-range addresses alias via index truncation (modulo DEPTH) and complete as normal transfers.

## Structure
- Package apb_pkg holds:
  - the FSM state enum (IDLE/SETUP/ACCESS)
  - the wait-counter width constant (4 bits)
  - localparam helpers for index width
- Sub-module apb_slv_mem: DEPTH x DATA_W single-port array with synchronous write and registered read, instanced by apb_mem_slave. The FSM, counter and error logic stay in the top.

## Test plan
- Reset: hold PRST = 0 mid-write at addr 5 -> PREADY/PSLVERR/PRDATA = 0; a subsequent read of addr 5 does not return the dropped data.
- WAIT_CYCLES = 0: write 0xA5 to addr 3, then read addr 3 -> PREADY in the first PENABLE cycle of each transfer; PRDATA = 0xA5.
- WAIT_CYCLES = 3: write 0x3C to addr 10 -> PREADY asserts exactly 4 cycles after the setup cycle; a read of addr 10 gives 0x3C with the same latency.
- Back-to-back: write 0x11 to addr 0 immediately followed by a read of addr 0 (no idle cycle) -> read returns 0x11.
- APB_SLV_ERR_EN, DEPTH = 64:
  - write 0xFF to addr 70 -> PSLVERR = 1 with PREADY; addr 6 unchanged.
  - read addr 70 -> PRDATA = 0, PSLVERR = 1.
  - Without the macro: the same write lands at addr 6 and PSLVERR stays 0.
- PENABLE dropped in a wait state (WAIT_CYCLES = 2) -> FSM returns to IDLE, no PREADY, write not committed.
